wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max grant cycles without wb_ack_i before error termination; 0 disables timeout.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-low.
REQ-004 mN_cyc_i  in  1  master N bus cycle, N=0 instruction fetch, N=1 load/store.
REQ-005 mN_stb_i  in  1  master N strobe; request = mN_cyc_i & mN_stb_i.
REQ-006 mN_we_i  in  1  master N write enable.
REQ-007 mN_adr_i  in  32  master N byte address.
REQ-008 mN_sel_i  in  4  master N byte selects.
REQ-009 mN_dat_i  in  32  master N write data.
REQ-010 mN_dat_o  out  32  read data to master N.
REQ-011 mN_ack_o  out  1  transfer-complete to master N.
REQ-012 mN_err_o  out  1  timeout error to master N.
REQ-013 wb_cyc_o / wb_stb_o / wb_we_o  out  1 each  slave-side cycle, strobe, write enable.
REQ-014 wb_adr_o  out  32  slave-side address.
REQ-015 wb_sel_o  out  4  slave-side byte selects.
REQ-016 wb_dat_o  out  32  slave-side write data.
REQ-017 wb_dat_i  in  32  slave read data.
REQ-018 wb_ack_i  in  1  slave acknowledge.
REQ-019 grant_o  out  2  one-hot current grant (bit N = master N); 00 in IDLE.

Function
REQ-020 FSM states SHALL be IDLE, GRANT0, GRANT1; arbitration decided only in IDLE, registered into GRANTn.
REQ-021 IDLE: single requester -> GRANTn next cycle; both -> master not equal to last_grant; none -> stay.
REQ-022 last_grant register SHALL update to n on each entry into GRANTn (round-robin).
REQ-023 In GRANTn: wb_cyc_o=mN_cyc_i, wb_stb_o=mN_stb_i, wb_we/adr/sel/dat_o = master n inputs, combinational.
REQ-024 Outside GRANTn all wb_* outputs SHALL be 0; non-granted master sees ack=0, err=0.
REQ-025 mN_dat_o SHALL equal wb_dat_i for both masters at all times (qualified by ack).
REQ-026 mN_ack_o = wb_ack_i in GRANTn, same cycle; ack -> IDLE next cycle.
REQ-027 Latency: request at cycle t in IDLE -> wb_stb_o at t+1; ack earliest t+1; new arbitration earliest t+2.
REQ-028 Granted master drops mN_cyc_i before ack -> IDLE next cycle, no ack/err issued.
REQ-029 Timeout counter SHALL clear on GRANT entry, increment each grant cycle with wb_ack_i=0, width $clog2(TIMEOUT+1).
REQ-030 If wb_ack_i=0 in the TIMEOUT-th grant cycle: mN_err_o=1 that cycle only, FSM -> IDLE next cycle.
REQ-031 wb_ack_i and timeout in same cycle: ack wins, err=0.
REQ-032 Requests from non-granted master SHALL be held off (no ack) until arbitrated; no request dropped.

Reset
REQ-033 rst_i=0 at clock edge: state=IDLE, last_grant=1 (master 0 wins first tie), counter=0.
REQ-034 During/after reset: grant_o=00, all wb_* outputs 0, all mN_ack_o/mN_err_o 0; reset mid-transaction abandons it without ack.

Verification
REQ-035 rst_i=0 two cycles, both masters requesting -> grant_o=00, wb_cyc_o=0, no ack/err; first grant after release is GRANT0.
REQ-036 m0 read adr 0x100 at t, slave acks at t+1 with 0xDEADBEEF -> t+1: grant_o=01, wb_adr_o=0x100, m0_ack_o=1, m0_dat_o=0xDEADBEEF; t+2 IDLE.
REQ-037 Both masters request continuously, slave acks 1st cycle -> grants alternate 01,10,01,10 with one IDLE cycle between.
REQ-038 TIMEOUT=16, m1 write, slave never acks -> m1_err_o=1 in 16th grant cycle only, wb_cyc_o=0 next cycle, m1_ack_o never 1.
REQ-039 wb_ack_i first asserted in 16th grant cycle -> m1_ack_o=1, m1_err_o=0.
REQ-040 rst_i=0 in 3rd grant cycle of m0 -> next cycle all outputs 0, grant_o=00, m0_ack_o stays 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin tie-break and grant timeout.
// Master 0 is instruction fetch and master 1 is load/store. Both share one slave.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [1:0]  grant_o
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic req0, req1;
  logic granted, gm;
  logic g_cyc, g_stb, g_we;
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;
  logic timeout_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  assign granted = (state == GRANT0) || (state == GRANT1);
  assign gm      = (state == GRANT1);

  assign g_cyc = gm ? m1_cyc_i : m0_cyc_i;
  assign g_stb = gm ? m1_stb_i : m0_stb_i;
  assign g_we  = gm ? m1_we_i  : m0_we_i;
  assign g_adr = gm ? m1_adr_i : m0_adr_i;
  assign g_sel = gm ? m1_sel_i : m0_sel_i;
  assign g_dat = gm ? m1_dat_i : m0_dat_i;

  // Counter holds (grant cycles so far - 1); an ack in the same cycle takes priority.
  assign timeout_hit = (TIMEOUT != 0) && granted && (cnt == CNT_LAST) && !wb_ack_i && g_cyc;

  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_sel_o = '0;
    wb_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = '0;

    // Outputs are also masked while reset is asserted so an abandoned transfer never acks.
    if (rst_i && granted) begin
      wb_cyc_o = g_cyc;
      wb_stb_o = g_stb;
      wb_we_o  = g_we;
      wb_adr_o = g_adr;
      wb_sel_o = g_sel;
      wb_dat_o = g_dat;
      grant_o  = gm ? 2'b10 : 2'b01;
      if (gm) begin
        m1_ack_o = wb_ack_i;
        m1_err_o = timeout_hit;
      end else begin
        m0_ack_o = wb_ack_i;
        m0_err_o = timeout_hit;
      end
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req0 && req1) begin
          state_nxt      = last_grant ? GRANT0 : GRANT1;
          last_grant_nxt = ~last_grant;
        end else if (req0) begin
          state_nxt      = GRANT0;
          last_grant_nxt = 1'b0;
        end else if (req1) begin
          state_nxt      = GRANT1;
          last_grant_nxt = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (wb_ack_i || timeout_hit || !g_cyc) state_nxt = IDLE;
        else cnt_nxt = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level owner/last/hold-count model.
module tb_wb_arbiter;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [1:0]  grant_o;

  wb_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .grant_o(grant_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (-1 none), who won last, cycles held so far.
  int owner  = -1;
  int last_g = 1;
  int held   = 0;

  int unsigned ack_pct;
  int n01, n10;
  logic [1:0] prev_g;
  logic alt_ok;

  task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic g, cyc_n, to, r0, r1;
    logic [1:0]  eg;
    logic [70:0] eb, ob;
    int n;
    #1;
    g     = rst_i && (owner >= 0);
    cyc_n = (owner == 1) ? m1_cyc_i : m0_cyc_i;
    to    = g && (TO != 0) && (held == int'(TO)) && !wb_ack_i && cyc_n;
    eg    = !g ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    eb    = '0;
    if (g)
      eb = (owner == 0) ? {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i}
                        : {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i};
    ob = {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o};
    check("grant", 71'(grant_o), 71'(eg));
    check("wb_bus", ob, eb);
    check("m0_ack", 71'(m0_ack_o), 71'(g && owner == 0 && wb_ack_i));
    check("m1_ack", 71'(m1_ack_o), 71'(g && owner == 1 && wb_ack_i));
    check("m0_err", 71'(m0_err_o), 71'(to && owner == 0));
    check("m1_err", 71'(m1_err_o), 71'(to && owner == 1));
    check("m0_dat", 71'(m0_dat_o), 71'(wb_dat_i));
    check("m1_dat", 71'(m1_dat_o), 71'(wb_dat_i));
    @(posedge clk);
    if (!rst_i) begin
      owner = -1; last_g = 1; held = 0;
    end else if (owner < 0) begin
      r0 = m0_cyc_i && m0_stb_i;
      r1 = m1_cyc_i && m1_stb_i;
      n  = -1;
      if (r0 && r1) n = (last_g == 0) ? 1 : 0;
      else if (r0)  n = 0;
      else if (r1)  n = 1;
      if (n >= 0) begin owner = n; last_g = n; held = 1; end
    end else begin
      if (wb_ack_i || to || !cyc_n) owner = -1;
      else held++;
    end
    @(negedge clk);
  endtask

  task automatic drop_all();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    wb_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    drop_all();
    m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
    m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    wb_dat_i = '0;
    @(negedge clk);

    // Reset held two cycles with both masters requesting; m0 wins the first tie.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h10; m0_sel_i = 4'hF;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h20; m1_sel_i = 4'h3;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    #1 check("first_grant", 71'(grant_o), 71'(2'b01));
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    tick();
    drop_all();
    tick();

    // m0 single read acked in first grant cycle.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
    m0_adr_i = 32'h100; m0_sel_i = 4'hF;
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    #1;
    check("rd_grant", 71'(grant_o), 71'(2'b01));
    check("rd_adr", 71'(wb_adr_o), 71'(32'h100));
    check("rd_ack", 71'(m0_ack_o), 71'(1'b1));
    check("rd_dat", 71'(m0_dat_o), 71'(32'hDEAD_BEEF));
    tick();
    drop_all();
    #1 check("rd_idle", 71'(grant_o), 71'(2'b00));
    tick();

    // Continuous contention with immediate acks must alternate.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    wb_ack_i = 1'b1;
    n01 = 0; n10 = 0; prev_g = 2'b00; alt_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (grant_o == 2'b01) n01++;
      if (grant_o == 2'b10) n10++;
      if (grant_o != 2'b00) begin
        if (prev_g == grant_o) alt_ok = 1'b0;
        prev_g = grant_o;
      end
      tick();
    end
    check("rr_n01", 71'(n01), 71'(2));
    check("rr_n10", 71'(n10), 71'(2));
    check("rr_alt", 71'(alt_ok), 71'(1'b1));
    drop_all();
    tick();

    // m1 write with no ack: error pulse in grant cycle 16 only.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_adr_i = 32'h400; m1_sel_i = 4'hC; m1_dat_i = 32'hCAFE_F00D;
    tick();
    for (int k = 1; k <= int'(TO); k++) begin
      #1;
      check("to_err", 71'(m1_err_o), 71'(k == int'(TO)));
      check("to_ack", 71'(m1_ack_o), 71'(1'b0));
      tick();
    end
    #1;
    check("to_cyc", 71'(wb_cyc_o), 71'(1'b0));
    check("to_idle", 71'(grant_o), 71'(2'b00));
    tick();

    // Ack first arriving in grant cycle 16 beats the timeout.
    for (int k = 1; k <= int'(TO); k++) begin
      wb_ack_i = (k == int'(TO));
      #1;
      check("late_ack", 71'(m1_ack_o), 71'(k == int'(TO)));
      check("late_err", 71'(m1_err_o), 71'(1'b0));
      tick();
    end
    drop_all();
    tick();

    // Reset in the third grant cycle of m0 abandons the transfer.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h200;
    tick();
    tick();
    tick();
    rst_i = 1'b0; wb_ack_i = 1'b1;
    #1 check("rst_ack", 71'(m0_ack_o), 71'(1'b0));
    tick();
    rst_i = 1'b1; wb_ack_i = 1'b0;
    #1;
    check("rst_grant", 71'(grant_o), 71'(2'b00));
    check("rst_cyc", 71'(wb_cyc_o), 71'(1'b0));
    tick();
    drop_all();
    tick();

    // Random traffic with sticky cycles and varying slave responsiveness.
    ack_pct = 25;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(2))
          0:       ack_pct = 0;
          1:       ack_pct = 25;
          default: ack_pct = 70;
        endcase
      end
      rst_i = ($urandom_range(99) != 0);
      if ($urandom_range(9) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(9) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = ($urandom_range(9) != 0);
      m1_stb_i = ($urandom_range(9) != 0);
      m0_we_i  = 1'($urandom_range(1));
      m1_we_i  = 1'($urandom_range(1));
      m0_adr_i = $urandom; m0_sel_i = 4'($urandom); m0_dat_i = $urandom;
      m1_adr_i = $urandom; m1_sel_i = 4'($urandom); m1_dat_i = $urandom;
      wb_dat_i = $urandom;
      wb_ack_i = ($urandom_range(99) < ack_pct);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
